// File: rtl/bin_to_ascii_dec.sv
// bin_to_ascii_dec
//   Sequential binary-to-decimal ASCII formatter. A captured unsigned value
//   is converted to BCD with the double-dabble algorithm (one input bit per
//   clock), then streamed out as fixed-width decimal characters, most
//   significant digit first, optionally followed by a terminator character.
//   All outputs come straight from registers.
module bin_to_ascii_dec #(
    parameter int         WIDTH   = 6,
    parameter int         DIGITS  = 2,
    parameter bit         TERM_EN = 1'b1,
    parameter logic [7:0] TERM    = 8'h0A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int BCDW   = 4 * DIGITS;
    localparam int NCHARS = DIGITS + (TERM_EN ? 1 : 0);
    localparam int IDXW   = (NCHARS > 1) ? $clog2(NCHARS) : 1;
    localparam int CNTW   = $clog2(WIDTH + 1);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHARS - 1);

    // The digit field must be able to hold the largest input value.
    if (10 ** DIGITS <= 2 ** WIDTH) begin : gParamCheck
        $error("bin_to_ascii_dec: DIGITS too small for WIDTH");
    end

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Double-dabble correction: every nibble of 5 or more gets +3 so that
    // the following left shift carries correctly into the next digit.
    function automatic logic [BCDW-1:0] addThree(input logic [BCDW-1:0] bcd);
        logic [BCDW-1:0] res;
        res = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end else begin
                res[4*d +: 4] = bcd[4*d +: 4];
            end
        end
        return res;
    endfunction

    // Character at stream position idx: digits first (MSD first), then the
    // terminator. A BCD nibble is at most 9, so 8'h30 + nibble is {3, nibble}.
    function automatic logic [7:0] charAt(input logic [BCDW-1:0] bcd,
                                          input logic [IDXW-1:0] idx);
        logic [7:0] ch;
        ch = TERM;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx == IDXW'(d)) begin
                ch = {4'h3, bcd[4*(DIGITS-1-d) +: 4]};
            end else begin
                ch = ch;
            end
        end
        return ch;
    endfunction

    // ------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------
    state_t            stateR,    stateS;
    logic [WIDTH-1:0]  binR,      binS;
    logic [BCDW-1:0]   bcdR,      bcdS;
    logic [CNTW-1:0]   cntR,      cntS;
    logic [IDXW-1:0]   idxR,      idxS;
    logic              outValidR, outValidS;
    logic [7:0]        outDataR,  outDataS;
    logic              outLastR,  outLastS;
    logic              inReadyR,  inReadyS;
    logic              busyR,     busyS;

    logic [BCDW-1:0]   adjBcdS;
    logic [BCDW-1:0]   shiftedBcdS;
    logic [IDXW-1:0]   nextIdxS;

    // Next-state and next-output logic for the IDLE/CONV/EMIT controller.
    always_comb begin
        stateS    = stateR;
        binS      = binR;
        bcdS      = bcdR;
        cntS      = cntR;
        idxS      = idxR;
        outValidS = outValidR;
        outDataS  = outDataR;
        outLastS  = outLastR;
        inReadyS  = inReadyR;
        busyS     = busyR;

        // One double-dabble step: correct, then shift the top input bit in.
        // The cast drops the corrected MSB, which is always zero here.
        adjBcdS     = addThree(bcdR);
        shiftedBcdS = BCDW'({adjBcdS, binR[WIDTH-1]});
        nextIdxS    = idxR + IDXW'(1);

        case (stateR)
            IDLE: begin
                if (in_valid && inReadyR) begin
                    stateS   = CONV;
                    binS     = in_data;
                    bcdS     = '0;
                    cntS     = CNTW'(WIDTH);
                    inReadyS = 1'b0;
                    busyS    = 1'b1;
                end else begin
                    inReadyS = 1'b1;
                end
            end

            CONV: begin
                bcdS = shiftedBcdS;
                binS = {binR[WIDTH-2:0], 1'b0};
                cntS = cntR - CNTW'(1);
                if (cntR == CNTW'(1)) begin
                    // Final shift: first character is presented on this edge.
                    stateS    = EMIT;
                    idxS      = '0;
                    outValidS = 1'b1;
                    outDataS  = charAt(shiftedBcdS, '0);
                    outLastS  = (LAST_IDX == '0);
                end else begin
                    stateS = CONV;
                end
            end

            EMIT: begin
                if (out_ready) begin
                    if (idxR == LAST_IDX) begin
                        stateS    = IDLE;
                        outValidS = 1'b0;
                        outDataS  = 8'h00;
                        outLastS  = 1'b0;
                        inReadyS  = 1'b1;
                        busyS     = 1'b0;
                        idxS      = '0;
                    end else begin
                        idxS     = nextIdxS;
                        outDataS = charAt(bcdR, nextIdxS);
                        outLastS = (nextIdxS == LAST_IDX);
                    end
                end else begin
                    // Consumer stalled: hold the character and its flags.
                    outValidS = 1'b1;
                end
            end

            default: begin
                stateS    = IDLE;
                outValidS = 1'b0;
                outDataS  = 8'h00;
                outLastS  = 1'b0;
                inReadyS  = 1'b1;
                busyS     = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset discards any work in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR    <= IDLE;
            binR      <= '0;
            bcdR      <= '0;
            cntR      <= '0;
            idxR      <= '0;
            outValidR <= 1'b0;
            outDataR  <= 8'h00;
            outLastR  <= 1'b0;
            inReadyR  <= 1'b1;
            busyR     <= 1'b0;
        end else begin
            stateR    <= stateS;
            binR      <= binS;
            bcdR      <= bcdS;
            cntR      <= cntS;
            idxR      <= idxS;
            outValidR <= outValidS;
            outDataR  <= outDataS;
            outLastR  <= outLastS;
            inReadyR  <= inReadyS;
            busyR     <= busyS;
        end
    end

    assign in_ready  = inReadyR;
    assign out_valid = outValidR;
    assign out_data  = outDataR;
    assign out_last  = outLastR;
    assign busy      = busyR;

endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// Directed testbench for bin_to_ascii_dec: default 6-bit/2-digit/terminated
// instance plus a 10-bit/4-digit instance without terminator.
module tb_bin_to_ascii_dec;

    logic clk = 1'b0;
    logic rstN;

    // Default instance
    logic       inValid, inReady, outValid, outReady, outLast, busy;
    logic [5:0] inData;
    logic [7:0] outData;

    // Wide instance
    logic       inValid2, inReady2, outValid2, outReady2, outLast2, busy2;
    logic [9:0] inData2;
    logic [7:0] outData2;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    bin_to_ascii_dec dut (
        .clk(clk), .rst_n(rstN),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .out_last(outLast), .busy(busy)
    );

    bin_to_ascii_dec #(.WIDTH(10), .DIGITS(4), .TERM_EN(1'b0), .TERM(8'h0A)) dut2 (
        .clk(clk), .rst_n(rstN),
        .in_valid(inValid2), .in_ready(inReady2), .in_data(inData2),
        .out_valid(outValid2), .out_ready(outReady2), .out_data(outData2),
        .out_last(outLast2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present v and hold until the accepting edge, then drop in_valid.
    task automatic sendVal(input string tag, input logic [5:0] v);
        inValid = 1'b1;
        inData  = v;
        for (int i = 0; i < 50; i++) begin
            if (inReady) break;
            step();
        end
        chk({tag, "_acc"}, {31'd0, inReady}, 32'd1);
        step();
        inValid = 1'b0;
    endtask

    // Wait for a character, check it and its last flag, then take it.
    task automatic recvChar(input string tag, input logic [7:0] ch, input logic last);
        outReady = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (outValid) break;
            step();
        end
        chk({tag, "_v"}, {31'd0, outValid}, 32'd1);
        chk({tag, "_d"}, {24'd0, outData}, {24'd0, ch});
        chk({tag, "_l"}, {31'd0, outLast}, {31'd0, last});
        step();
    endtask

    // Count edges from the accepting edge until out_valid rises.
    task automatic measureLat(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (outValid) break;
            step();
            n++;
        end
    endtask

    logic [7:0] exp2 [4];

    initial begin
        exp2 = '{8'h31, 8'h30, 8'h32, 8'h33};
        rstN = 1'b0;
        inValid = 1'b0; inData = 6'd0; outReady = 1'b0;
        inValid2 = 1'b0; inData2 = 10'd0; outReady2 = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_in_ready",  {31'd0, inReady},  32'd1);
        chk("rst_out_valid", {31'd0, outValid}, 32'd0);
        chk("rst_out_data",  {24'd0, outData},  32'h00);
        chk("rst_out_last",  {31'd0, outLast},  32'd0);
        chk("rst_busy",      {31'd0, busy},     32'd0);
        #2 rstN = 1'b1;
        step();
        chk("post_rst_valid", {31'd0, outValid}, 32'd0);

        // 1: zero, latency, leading zeros, last flag
        outReady = 1'b1;
        sendVal("t1", 6'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_inrdy", {31'd0, inReady}, 32'd0);
        measureLat(lat);
        chk("t1_lat", lat, 32'd6);
        recvChar("t1c0", 8'h30, 1'b0);
        recvChar("t1c1", 8'h30, 1'b0);
        recvChar("t1c2", 8'h0A, 1'b1);
        chk("t1_idle_valid", {31'd0, outValid}, 32'd0);
        chk("t1_idle_busy",  {31'd0, busy},     32'd0);

        // 2: maximum
        sendVal("t2", 6'd63);
        recvChar("t2c0", 8'h36, 1'b0);
        recvChar("t2c1", 8'h33, 1'b0);
        recvChar("t2c2", 8'h0A, 1'b1);

        // 3: 31+31
        sendVal("t3", 6'd62);
        recvChar("t3c0", 8'h36, 1'b0);
        recvChar("t3c1", 8'h32, 1'b0);
        recvChar("t3c2", 8'h0A, 1'b1);

        // 4: backpressure holds the first character
        outReady = 1'b0;
        sendVal("t4", 6'd19);
        measureLat(lat);
        chk("t4_lat", lat, 32'd6);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_v", {31'd0, outValid}, 32'd1);
            chk("t4_hold_d", {24'd0, outData},  32'h31);
            chk("t4_hold_l", {31'd0, outLast},  32'd0);
            step();
        end
        recvChar("t4c0", 8'h31, 1'b0);
        recvChar("t4c1", 8'h39, 1'b0);
        recvChar("t4c2", 8'h0A, 1'b1);
        chk("t4_done", {31'd0, outValid}, 32'd0);

        // 5: asynchronous reset mid-conversion
        sendVal("t5", 6'd42);
        step();
        step();
        #1 rstN = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, outValid}, 32'd0);
        chk("t5_rst_rdy",   {31'd0, inReady},  32'd1);
        chk("t5_rst_busy",  {31'd0, busy},     32'd0);
        #1 rstN = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_stale", {31'd0, outValid}, 32'd0);
            step();
        end
        sendVal("t5b", 6'd7);
        recvChar("t5c0", 8'h30, 1'b0);
        recvChar("t5c1", 8'h37, 1'b0);
        recvChar("t5c2", 8'h0A, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_extra", {31'd0, outValid}, 32'd0);
            step();
        end

        // 6: in_valid held high across two values
        outReady = 1'b1;
        inValid = 1'b1;
        inData  = 6'd10;
        step();
        inData  = 6'd55;
        for (int i = 0; i < 6; i++) begin
            chk("t6_rdy_conv", {31'd0, inReady}, 32'd0);
            step();
        end
        chk("t6_rdy_e0", {31'd0, inReady}, 32'd0);
        recvChar("t6c0", 8'h31, 1'b0);
        chk("t6_rdy_e1", {31'd0, inReady}, 32'd0);
        recvChar("t6c1", 8'h30, 1'b0);
        chk("t6_rdy_e2", {31'd0, inReady}, 32'd0);
        recvChar("t6c2", 8'h0A, 1'b1);
        chk("t6_rdy_back", {31'd0, inReady},  32'd1);
        chk("t6_gap_valid", {31'd0, outValid}, 32'd0);
        step();
        inValid = 1'b0;
        chk("t6_rdy_acc2", {31'd0, inReady}, 32'd0);
        recvChar("t6c3", 8'h35, 1'b0);
        recvChar("t6c4", 8'h35, 1'b0);
        recvChar("t6c5", 8'h0A, 1'b1);

        // 7: wide instance, no terminator
        outReady2 = 1'b1;
        chk("t7_rdy", {31'd0, inReady2}, 32'd1);
        inValid2 = 1'b1;
        inData2  = 10'd1023;
        step();
        inValid2 = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (outValid2) break;
            step();
            lat++;
        end
        chk("t7_lat", lat, 32'd10);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20; i++) begin
                if (outValid2) break;
                step();
            end
            chk("t7_v", {31'd0, outValid2}, 32'd1);
            chk("t7_d", {24'd0, outData2}, {24'd0, exp2[k]});
            chk("t7_l", {31'd0, outLast2}, (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("t7_done", {31'd0, outValid2}, 32'd0);
        chk("t7_busy", {31'd0, busy2},     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
